// File: rtl/elevator_scheduler_if.sv
// elevator_scheduler_if
//   Bundles the request inputs, car-controller feedback and scheduler outputs
//   of elevator_scheduler into one port.
//   master : call/request logic plus car controller (drives requests and car status)
//   slave  : the scheduler itself
//   Signals:
//     req_valid/req_floor   call request strobe and floor
//     car_floor/car_finish  car position and arrival report
//     dest_floor            destination handed to the car controller
//     door_open, dir_up     door state and current sweep direction
//     pending, busy         outstanding call bitmap and activity flag
interface elevator_scheduler_if #(
    parameter int NUM_FLOORS = 6,
    parameter int FLOOR_W    = 3
);
    logic                  req_valid;
    logic [FLOOR_W-1:0]    req_floor;
    logic [FLOOR_W-1:0]    car_floor;
    logic                  car_finish;
    logic [FLOOR_W-1:0]    dest_floor;
    logic                  door_open;
    logic                  dir_up;
    logic [NUM_FLOORS-1:0] pending;
    logic                  busy;

    modport master (
        output req_valid, req_floor, car_floor, car_finish,
        input  dest_floor, door_open, dir_up, pending, busy
    );

    modport slave (
        input  req_valid, req_floor, car_floor, car_finish,
        output dest_floor, door_open, dir_up, pending, busy
    );
endinterface

// File: rtl/elevator_scheduler.sv
// elevator_scheduler
//   Collects floor calls into a pending bitmap and steers a single car with a
//   SCAN policy: keep travelling in the current direction while calls remain
//   ahead, reverse only when idle. The door is held open for DOOR_CYCLES clocks
//   at every serviced floor.
//   Ports:
//     clk  clock
//     rst  synchronous, active-high reset
//     bus  elevator_scheduler_if.slave
//          in : req_valid, req_floor, car_floor, car_finish
//          out: dest_floor, door_open, dir_up, pending (registered), busy
module elevator_scheduler #(
    parameter int NUM_FLOORS  = 6,
    parameter int FLOOR_W     = 3,
    parameter int DOOR_CYCLES = 20
) (
    input logic                 clk,
    input logic                 rst,
    elevator_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        MOVING,
        DOOR
    } state_t;

    localparam int               TW         = $clog2(DOOR_CYCLES);
    localparam logic [TW-1:0]    DWELL_LOAD = TW'(DOOR_CYCLES - 1);

    state_t                state;
    logic [FLOOR_W-1:0]    dest_floor;
    logic                  door_open;
    logic                  dir_up;
    logic [NUM_FLOORS-1:0] pending;
    logic [TW-1:0]         timer;

    logic                  up_found;
    logic                  dn_found;
    logic [FLOOR_W-1:0]    up_tgt;
    logic [FLOOR_W-1:0]    dn_tgt;
    logic                  here_pend;
    logic                  req_ok;
    logic                  arrive;
    logic [NUM_FLOORS-1:0] clr_mask;
    logic [NUM_FLOORS-1:0] set_mask;

    // Nearest calls above and below the car, plus a call at the car's floor.
    always_comb begin
        up_found  = 1'b0;
        dn_found  = 1'b0;
        up_tgt    = '0;
        dn_tgt    = '0;
        here_pend = 1'b0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && (FLOOR_W'(i) > bus.car_floor) && !up_found) begin
                up_found = 1'b1;
                up_tgt   = FLOOR_W'(i);
            end
            if (pending[i] && (FLOOR_W'(i) < bus.car_floor)) begin
                dn_found = 1'b1;
                dn_tgt   = FLOOR_W'(i);
            end
            if (pending[i] && (FLOOR_W'(i) == bus.car_floor)) begin
                here_pend = 1'b1;
            end
        end
    end

    // A bit being cleared this cycle wins over a same-cycle request for it,
    // and a request for the open-door floor never re-arms a call.
    always_comb begin
        req_ok   = bus.req_valid && (int'(bus.req_floor) < NUM_FLOORS);
        arrive   = (state == MOVING) && bus.car_finish && (bus.car_floor == dest_floor);
        clr_mask = '0;
        set_mask = '0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            clr_mask[i] = ((state == IDLE) && here_pend && (bus.car_floor == FLOOR_W'(i))) ||
                          (arrive && (dest_floor == FLOOR_W'(i)));
        end
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            set_mask[i] = req_ok && (bus.req_floor == FLOOR_W'(i)) && !clr_mask[i] &&
                          !((state == DOOR) && (bus.req_floor == bus.car_floor));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pending    <= '0;
            dest_floor <= '0;
            door_open  <= 1'b0;
            dir_up     <= 1'b1;
            timer      <= '0;
        end else begin
            pending <= (pending & ~clr_mask) | set_mask;
            case (state)
                IDLE: begin
                    dest_floor <= bus.car_floor;
                    if (here_pend) begin
                        door_open <= 1'b1;
                        timer     <= DWELL_LOAD;
                        state     <= DOOR;
                    end else if (dir_up && up_found) begin
                        dest_floor <= up_tgt;
                        state      <= MOVING;
                    end else if (dn_found) begin
                        dir_up     <= 1'b0;
                        dest_floor <= dn_tgt;
                        state      <= MOVING;
                    end else if (up_found) begin
                        dir_up     <= 1'b1;
                        dest_floor <= up_tgt;
                        state      <= MOVING;
                    end
                end
                MOVING: begin
                    if (arrive) begin
                        door_open <= 1'b1;
                        timer     <= DWELL_LOAD;
                        state     <= DOOR;
                    end else if (dir_up && up_found && (up_tgt < dest_floor)) begin
                        // Intercept: a nearer call ahead on the way up.
                        dest_floor <= up_tgt;
                    end else if (!dir_up && dn_found && (dn_tgt > dest_floor)) begin
                        // Intercept: a nearer call ahead on the way down.
                        dest_floor <= dn_tgt;
                    end
                end
                DOOR: begin
                    if (timer == '0) begin
                        door_open <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.dest_floor = dest_floor;
    assign bus.door_open  = door_open;
    assign bus.dir_up     = dir_up;
    assign bus.pending    = pending;
    assign bus.busy       = (state != IDLE) || (pending != '0);

endmodule

// File: tb/tb_elevator_scheduler.sv
// tb_elevator_scheduler
//   Directed scenarios for elevator_scheduler with a simple car model that
//   steps one floor every MOVE_CYC clocks toward dest_floor. Stimulus queues
//   expected destination changes, door openings and state snapshots; a
//   separate monitor compares them against the DUT on the falling edge.
module tb_elevator_scheduler;

    localparam int NF       = 6;
    localparam int FW       = 3;
    localparam int DC       = 20;
    localparam int MOVE_CYC = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    elevator_scheduler_if #(.NUM_FLOORS(NF), .FLOOR_W(FW)) bus ();

    elevator_scheduler #(
        .NUM_FLOORS (NF),
        .FLOOR_W    (FW),
        .DOOR_CYCLES(DC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef enum int {
        K_PENDING,
        K_DEST,
        K_DOOR,
        K_DIR,
        K_BUSY,
        K_TIMEOUT,
        K_LEFTOVER
    } kind_t;

    typedef struct {
        kind_t kind;
        int    val;
    } snap_t;

    snap_t snap_q[$];
    int    exp_dest_q[$];
    int    exp_door_q[$];

    int checks   = 0;
    int errors   = 0;
    int timeouts = 0;
    int move_cnt = 0;

    task automatic compare(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: the only process that steps checks/errors.
    initial begin
        snap_t      s;
        logic [FW-1:0] last_dest;
        logic       last_door;
        int         dwell;
        last_dest = '0;
        last_door = 1'b0;
        dwell     = 0;
        forever begin
            @(negedge clk);
            while (snap_q.size() > 0) begin
                s = snap_q.pop_front();
                case (s.kind)
                    K_PENDING:  compare("pending", int'(bus.pending), s.val);
                    K_DEST:     compare("dest_floor_snap", int'(bus.dest_floor), s.val);
                    K_DOOR:     compare("door_open_snap", int'(bus.door_open), s.val);
                    K_DIR:      compare("dir_up", int'(bus.dir_up), s.val);
                    K_BUSY:     compare("busy", int'(bus.busy), s.val);
                    K_TIMEOUT:  compare("wait_timeouts", s.val, 0);
                    K_LEFTOVER: compare("unmet_expectations", s.val, 0);
                    default:    compare("snap_kind", int'(s.kind), 0);
                endcase
            end
            if (!rst) begin
                if (bus.dest_floor != last_dest) begin
                    if (exp_dest_q.size() == 0)
                        compare("unexpected_dest_change", int'(bus.dest_floor), int'(last_dest));
                    else
                        compare("dest_floor", int'(bus.dest_floor), exp_dest_q.pop_front());
                    last_dest = bus.dest_floor;
                end
                if (bus.door_open && !last_door) begin
                    dwell = 0;
                    if (exp_door_q.size() == 0)
                        compare("unexpected_door_open", 1, 0);
                    else
                        compare("door_floor", int'(bus.car_floor), exp_door_q.pop_front());
                end
                if (bus.door_open) dwell++;
                if (!bus.door_open && last_door) compare("door_dwell", dwell, DC);
                last_door = bus.door_open;
            end
        end
    end

    // One clock of stimulus, followed by the car model update.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.car_floor == bus.dest_floor) begin
            move_cnt = 0;
        end else begin
            move_cnt++;
            if (move_cnt >= MOVE_CYC) begin
                move_cnt = 0;
                if (bus.car_floor < bus.dest_floor) bus.car_floor = bus.car_floor + 1'b1;
                else                                bus.car_floor = bus.car_floor - 1'b1;
            end
        end
        bus.car_finish = (bus.car_floor == bus.dest_floor);
    endtask

    task automatic set_car(input int f);
        bus.car_floor  = FW'(f);
        move_cnt       = 0;
        bus.car_finish = (bus.car_floor == bus.dest_floor);
    endtask

    task automatic snap(input kind_t k, input int v);
        snap_q.push_back('{kind: k, val: v});
    endtask

    task automatic request(input int f);
        bus.req_valid = 1'b1;
        bus.req_floor = FW'(f);
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        for (int n = 0; n < max; n++) begin
            if (!bus.busy && exp_dest_q.size() == 0 && exp_door_q.size() == 0) return;
            tick();
        end
        timeouts++;
        $display("FAIL wait_idle: still busy after %0d cycles, expected idle", max);
    endtask

    task automatic wait_car(input int f, input int max);
        for (int n = 0; n < max; n++) begin
            if (int'(bus.car_floor) == f) return;
            tick();
        end
        timeouts++;
        $display("FAIL wait_car: car_floor %0d after %0d cycles, expected %0d",
                 bus.car_floor, max, f);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_floor  = '0;
        bus.car_floor  = '0;
        bus.car_finish = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        snap(K_DEST, 0);
        snap(K_DOOR, 0);
        snap(K_PENDING, 0);
        snap(K_BUSY, 0);
        snap(K_DIR, 1);

        // Car at 0, call to 3.
        exp_dest_q.push_back(3);
        exp_door_q.push_back(3);
        request(3);
        snap(K_PENDING, 6'b001000);
        wait_idle(400);
        snap(K_PENDING, 0);

        // Moving 0->5, intercept at 2 while passing floor 1.
        set_car(0);
        exp_dest_q.push_back(0);
        tick();
        tick();
        exp_dest_q.push_back(5);
        request(5);
        wait_car(1, 100);
        exp_dest_q.push_back(2);
        exp_door_q.push_back(2);
        exp_dest_q.push_back(5);
        exp_door_q.push_back(5);
        request(2);
        wait_idle(400);
        snap(K_DIR, 1);
        snap(K_PENDING, 0);

        // Car at 2 going up, calls {4,0}: 4 first, then reverse to 0.
        set_car(2);
        exp_dest_q.push_back(2);
        tick();
        tick();
        exp_dest_q.push_back(4);
        exp_door_q.push_back(4);
        exp_dest_q.push_back(0);
        exp_door_q.push_back(0);
        request(4);
        request(0);
        snap(K_PENDING, 6'b010001);
        snap(K_DIR, 1);
        wait_idle(400);
        snap(K_DIR, 0);

        // Idle at 3, call at own floor: absorbed while clearing and during dwell.
        set_car(3);
        exp_dest_q.push_back(3);
        tick();
        tick();
        exp_door_q.push_back(3);
        bus.req_valid = 1'b1;
        bus.req_floor = 3'd3;
        tick();
        snap(K_PENDING, 6'b001000);
        snap(K_DOOR, 0);
        tick();
        snap(K_PENDING, 0);
        snap(K_DOOR, 1);
        tick();
        snap(K_PENDING, 0);
        snap(K_DEST, 3);
        bus.req_valid = 1'b0;
        wait_idle(100);
        request(6);
        snap(K_PENDING, 0);
        snap(K_BUSY, 0);
        request(7);
        snap(K_PENDING, 0);
        snap(K_BUSY, 0);

        // Reset mid-move with calls {1,5} pending.
        exp_dest_q.push_back(5);
        request(5);
        request(1);
        snap(K_DIR, 1);
        tick();
        snap(K_PENDING, 6'b100010);
        exp_dest_q.push_back(0);
        rst = 1'b1;
        set_car(0);
        tick();
        rst = 1'b0;
        snap(K_PENDING, 0);
        snap(K_DEST, 0);
        snap(K_DOOR, 0);
        snap(K_DIR, 1);
        snap(K_BUSY, 0);
        repeat (3) tick();

        wait_idle(50);
        snap(K_LEFTOVER, exp_dest_q.size() + exp_door_q.size());
        snap(K_TIMEOUT, timeouts);
        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
